// File: rtl/instr_fetch_queue_if.sv
// Fetch-to-memory and fetch-to-decode signal bundle for instr_fetch_queue.
// master = fetch queue side, slave = memory/consumer side.
interface instr_fetch_queue_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
);
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_instr;
  logic               jump_en;
  logic [ADDR_W-1:0]  jump_target;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr_out;
  logic [ADDR_W-1:0]  pc_out;
  logic               halt;
  logic [15:0]        perf_fetch;
  logic [15:0]        perf_stall;
  logic [15:0]        perf_flush;

  modport master (
    output imem_addr, input imem_instr,
    input  jump_en, input jump_target,
    output instr_valid, input instr_ready, output instr_out, output pc_out, output halt,
    output perf_fetch, output perf_stall, output perf_flush
  );

  modport slave (
    input  imem_addr, output imem_instr,
    output jump_en, output jump_target,
    input  instr_valid, output instr_ready, input instr_out, input pc_out, input halt,
    input  perf_fetch, input perf_stall, input perf_flush
  );
endinterface

// File: rtl/instr_fetch_queue.sv
// Fetch PC owner plus prefetch FIFO of {address, word}; jump flush and halt-on-zero.
// Optional FETCH_PERF_EN builds saturating fetch/stall/flush counters; otherwise perf_* read 0.
module instr_fetch_queue #(
  parameter int               DEPTH    = 4,
  parameter int               ADDR_W   = 8,
  parameter int               INSTR_W  = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic               clk,
  input logic               rst_n,
  instr_fetch_queue_if.master bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [ADDR_W-1:0]  pc_mem   [DEPTH];
  logic [INSTR_W-1:0] word_mem [DEPTH];

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              halted_q, halted_d;
  logic              valid, push, pop;

  assign valid = (count_q != '0);
  // A jump cycle records neither a push nor a pop.
  assign pop   = valid && bus.instr_ready && !bus.jump_en;
  assign push  = !bus.jump_en && !halted_q && ((count_q < DEPTH_C) || pop);

  assign bus.imem_addr   = fetch_pc_q;
  assign bus.instr_valid = valid;
  assign bus.instr_out   = valid ? word_mem[rd_ptr_q] : '0;
  assign bus.pc_out      = valid ? pc_mem[rd_ptr_q]   : '0;
  assign bus.halt        = valid && (word_mem[rd_ptr_q] == '0);

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    halted_d   = halted_q;
    if (bus.jump_en) begin
      fetch_pc_d = bus.jump_target;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      halted_d   = 1'b0;
    end else begin
      if (push) begin
        fetch_pc_d = fetch_pc_q + ADDR_W'(1);
        wr_ptr_d   = wr_ptr_q + PTR_W'(1);
        if (bus.imem_instr == '0) halted_d = 1'b1;
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      halted_q   <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      halted_q   <= halted_d;
    end
  end

  // Storage carries no reset; count_q alone decides which entries are live.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (push && (wr_ptr_q == PTR_W'(gi))) begin
        pc_mem[gi]   <= fetch_pc_q;
        word_mem[gi] <= bus.imem_instr;
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic [15:0] perf_fetch_q, perf_stall_q, perf_flush_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (push && (perf_fetch_q != 16'hFFFF)) perf_fetch_q <= perf_fetch_q + 16'd1;
      if (valid && !bus.instr_ready && (perf_stall_q != 16'hFFFF))
        perf_stall_q <= perf_stall_q + 16'd1;
      if (bus.jump_en && (perf_flush_q != 16'hFFFF)) perf_flush_q <= perf_flush_q + 16'd1;
    end
  end

  assign bus.perf_fetch = perf_fetch_q;
  assign bus.perf_stall = perf_stall_q;
  assign bus.perf_flush = perf_flush_q;
`else
  assign bus.perf_fetch = 16'h0000;
  assign bus.perf_stall = 16'h0000;
  assign bus.perf_flush = 16'h0000;
`endif
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench for instr_fetch_queue: expected {pc, word} queued from the memory
// model when stimulus is set up, popped on each observed handshake.
module tb_instr_fetch_queue;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  instr_fetch_queue_if #(.ADDR_W(8), .INSTR_W(16)) bus ();

  instr_fetch_queue #(
    .DEPTH(4), .ADDR_W(8), .INSTR_W(16), .RESET_PC(8'h00)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [15:0] mem [256];
  assign bus.imem_instr = mem[bus.imem_addr];

  int errors = 0;
  int checks = 0;
  logic [23:0] sb [$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic fill_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
  endtask

  task automatic push_range(input logic [7:0] start, input int n);
    logic [7:0] a;
    for (int i = 0; i < n; i++) begin
      a = start + 8'(i);
      sb.push_back({a, mem[a]});
    end
  endtask

  task automatic drain(input int budget);
    int left;
    logic [23:0] e;
    left = budget;
    while (sb.size() > 0 && left > 0) begin
      if (bus.instr_valid && bus.instr_ready) begin
        e = sb.pop_front();
        checks++;
        if (bus.instr_out !== e[15:0] || bus.pc_out !== e[23:16]) begin
          errors++;
          $display("FAIL drain_word: got pc=%h word=%h, expected pc=%h word=%h",
                   bus.pc_out, bus.instr_out, e[23:16], e[15:0]);
        end
        checks++;
        if (bus.halt !== (e[15:0] == 16'h0000)) begin
          errors++;
          $display("FAIL drain_halt: got %b, expected %b", bus.halt, e[15:0] == 16'h0000);
        end
        $display("pop pc=%h word=%h halt=%b", bus.pc_out, bus.instr_out, bus.halt);
      end
      step();
      left--;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d words outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.jump_en = 1'b0;
    bus.jump_target = 8'h00;
    bus.instr_ready = 1'b0;
    fill_mem();
    #12;
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.instr_out !== 16'h0 || bus.pc_out !== 8'h0 || bus.halt !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b out=%h pc=%h halt=%b, expected 0 0 0 0",
               bus.instr_valid, bus.instr_out, bus.pc_out, bus.halt);
    end
    checks++;
    if (bus.imem_addr !== 8'h00) begin
      errors++;
      $display("FAIL reset_imem_addr: got %h, expected 00", bus.imem_addr);
    end
    checks++;
    if (bus.perf_fetch !== 16'h0 || bus.perf_stall !== 16'h0 || bus.perf_flush !== 16'h0) begin
      errors++;
      $display("FAIL reset_perf: got %h %h %h, expected 0 0 0",
               bus.perf_fetch, bus.perf_stall, bus.perf_flush);
    end
  endtask

  task automatic test_halt();
    fill_mem();
    mem[0] = 16'h8001; mem[1] = 16'h9002; mem[2] = 16'hA003; mem[3] = 16'h0000;
    bus.instr_ready = 1'b1;
    do_reset();
    push_range(8'h00, 4);
    drain(10);
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.halt !== 1'b0) begin
      errors++;
      $display("FAIL halt_empty: valid=%b halt=%b, expected 0 0", bus.instr_valid, bus.halt);
    end
    step(); step(); step();
    checks++;
    if (bus.imem_addr !== 8'h04 || bus.instr_valid !== 1'b0) begin
      errors++;
      $display("FAIL halt_frozen: imem_addr=%h valid=%b, expected 04 0", bus.imem_addr, bus.instr_valid);
    end
`ifdef FETCH_PERF_EN
    checks++;
    if (bus.perf_fetch !== 16'd4) begin
      errors++;
      $display("FAIL perf_fetch_halt: got %0d, expected 4", bus.perf_fetch);
    end
`endif
  endtask

  task automatic test_backpressure();
    logic [23:0] e;
    fill_mem();
    bus.instr_ready = 1'b0;
    do_reset();
    for (int k = 0; k < 9; k++) begin
      step();
      checks++;
      if (bus.instr_valid !== 1'b1 || bus.instr_out !== 16'h1000 || bus.pc_out !== 8'h00) begin
        errors++;
        $display("FAIL stall_head: cycle %0d valid=%b out=%h pc=%h, expected 1 1000 00",
                 k, bus.instr_valid, bus.instr_out, bus.pc_out);
      end
    end
    checks++;
    if (bus.imem_addr !== 8'h04) begin
      errors++;
      $display("FAIL stall_imem_addr: got %h, expected 04", bus.imem_addr);
    end
`ifdef FETCH_PERF_EN
    checks++;
    if (bus.perf_stall < 16'd8 || bus.perf_flush !== 16'd0) begin
      errors++;
      $display("FAIL perf_stall: stall=%0d flush=%0d, expected >=8 and 0", bus.perf_stall, bus.perf_flush);
    end
`else
    checks++;
    if (bus.perf_fetch !== 16'h0 || bus.perf_stall !== 16'h0 || bus.perf_flush !== 16'h0) begin
      errors++;
      $display("FAIL perf_tied: got %h %h %h, expected 0 0 0", bus.perf_fetch, bus.perf_stall, bus.perf_flush);
    end
`endif
    // Full FIFO drained at one word per cycle: a push must land every cycle too.
    bus.instr_ready = 1'b1;
    push_range(8'h00, 8);
    for (int k = 0; k < 8; k++) begin
      e = sb.pop_front();
      checks++;
      if (bus.instr_valid !== 1'b1 || bus.instr_out !== e[15:0] || bus.pc_out !== e[23:16]) begin
        errors++;
        $display("FAIL stream_word: valid=%b pc=%h word=%h, expected 1 %h %h",
                 bus.instr_valid, bus.pc_out, bus.instr_out, e[23:16], e[15:0]);
      end
      checks++;
      if (bus.imem_addr !== 8'(4 + k)) begin
        errors++;
        $display("FAIL stream_imem_addr: got %h, expected %h", bus.imem_addr, 8'(4 + k));
      end
      $display("pop pc=%h word=%h", bus.pc_out, bus.instr_out);
      step();
    end
  endtask

  task automatic test_jump();
    bus.instr_ready = 1'b0;
    step(); step();
    bus.jump_en = 1'b1;
    bus.jump_target = 8'h20;
    bus.instr_ready = 1'b1;
    step();
    bus.jump_en = 1'b0;
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.imem_addr !== 8'h20) begin
      errors++;
      $display("FAIL jump_bubble: valid=%b imem_addr=%h, expected 0 20", bus.instr_valid, bus.imem_addr);
    end
    step();
    checks++;
    if (bus.instr_valid !== 1'b1 || bus.instr_out !== mem[8'h20] || bus.pc_out !== 8'h20) begin
      errors++;
      $display("FAIL jump_target_word: valid=%b pc=%h word=%h, expected 1 20 %h",
               bus.instr_valid, bus.pc_out, bus.instr_out, mem[8'h20]);
    end
    step();
    push_range(8'h21, 3);
    drain(10);
`ifdef FETCH_PERF_EN
    checks++;
    if (bus.perf_flush !== 16'd1) begin
      errors++;
      $display("FAIL perf_flush: got %0d, expected 1", bus.perf_flush);
    end
`endif
  endtask

  task automatic test_wrap();
    bus.jump_en = 1'b1;
    bus.jump_target = 8'hFE;
    step();
    bus.jump_en = 1'b0;
    push_range(8'hFE, 4);
    drain(12);
  endtask

  task automatic test_async_reset();
    step(); step();
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.instr_valid !== 1'b0 || bus.instr_out !== 16'h0 || bus.pc_out !== 8'h0 || bus.halt !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_outputs: valid=%b out=%h pc=%h halt=%b, expected 0 0 0 0",
               bus.instr_valid, bus.instr_out, bus.pc_out, bus.halt);
    end
    checks++;
    if (bus.imem_addr !== 8'h00 || bus.perf_fetch !== 16'h0) begin
      errors++;
      $display("FAIL async_reset_state: imem_addr=%h perf_fetch=%h, expected 00 0000",
               bus.imem_addr, bus.perf_fetch);
    end
    step();
    rst_n = 1'b1;
    push_range(8'h00, 4);
    drain(10);
  endtask

  initial begin
    test_reset();
    test_halt();
    test_backpressure();
    test_jump();
    test_wrap();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
